// File: rtl/gpi_conditioner.sv
// Synchronizes, debounces and edge-flags raw board inputs feeding the processor GPI bus.
// Sticky rise/fall flags (write-1-to-clear, set wins) drive a registered, maskable level interrupt.
module gpi_conditioner #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1000,
    parameter int STABLE   = 4
) (
    input  logic             XCLK,
    input  logic             XRESET_N,
    input  logic [WIDTH-1:0] gpi_raw,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] gpi_out,
    output logic [WIDTH-1:0] rise_pend,
    output logic [WIDTH-1:0] fall_pend,
    output logic             irq,
    output logic             ready
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(STABLE);

    logic [WIDTH-1:0]          meta_q, sync_q;
    logic [PW-1:0]             pre_q, pre_d;
    logic                      tick;
    logic [WIDTH-1:0][DW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]          out_q, out_d;
    logic [WIDTH-1:0]          rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0]          rise_set, fall_set;
    logic                      irq_q, irq_d;
    logic [2:0]                rt_q, rt_d;
    logic                      ready_q, ready_d;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d    = tick ? '0 : pre_q + 1'b1;
        out_d    = out_q;
        cnt_d    = cnt_q;
        rise_set = '0;
        fall_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (sync_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == DW'(STABLE - 1)) begin
                    cnt_d[i]    = '0;
                    out_d[i]    = sync_q[i];
                    // Changes accepted before ready only settle the level, never flag.
                    rise_set[i] = sync_q[i] & ready_q;
                    fall_set[i] = ~sync_q[i] & ready_q;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise_d  = (rise_q & ~clr) | rise_set;
        fall_d  = (fall_q & ~clr) | fall_set;
        irq_d   = |((rise_q | fall_q) & irq_mask);
        rt_d    = (tick && rt_q != 3'd7) ? rt_q + 3'd1 : rt_q;
        ready_d = ready_q | (tick && (int'(rt_q) >= STABLE - 1));
    end

    always_ff @(posedge XCLK or negedge XRESET_N) begin
        if (!XRESET_N) begin
            meta_q  <= '0;
            sync_q  <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
            rt_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            meta_q  <= gpi_raw;
            sync_q  <= meta_q;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            rt_q    <= rt_d;
            ready_q <= ready_d;
        end
    end

    assign gpi_out   = out_q;
    assign rise_pend = rise_q;
    assign fall_pend = fall_q;
    assign irq       = irq_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_gpi_conditioner.sv
// Directed bench for gpi_conditioner at PRESCALE=4, STABLE=3: a timeline table
// (inputs, edges to advance, expected outputs) plus hand sequences for reset corners.
module tb_gpi_conditioner;

    logic        XCLK = 1'b0;
    logic        XRESET_N;
    logic [31:0] gpi_raw, irq_mask, clr;
    logic [31:0] gpi_out, rise_pend, fall_pend;
    logic        irq, ready;

    int total = 0;
    int bad   = 0;

    gpi_conditioner #(.WIDTH(32), .PRESCALE(4), .STABLE(3)) dut (
        .XCLK      (XCLK),
        .XRESET_N  (XRESET_N),
        .gpi_raw   (gpi_raw),
        .irq_mask  (irq_mask),
        .clr       (clr),
        .gpi_out   (gpi_out),
        .rise_pend (rise_pend),
        .fall_pend (fall_pend),
        .irq       (irq),
        .ready     (ready)
    );

    always #5 XCLK = ~XCLK;

    typedef struct {
        logic [31:0] raw;
        logic [31:0] mask;
        logic [31:0] clr;
        int          cyc;
        logic [31:0] out;
        logic [31:0] rise;
        logic [31:0] fall;
        logic        irq;
        logic        rdy;
    } vec_t;

    vec_t tbl [14];

    task automatic step(input int n);
        repeat (n) @(posedge XCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] o, input logic [31:0] r,
                           input logic [31:0] f, input logic i, input logic rd);
        chk({tag, " gpi_out"},   gpi_out,   o);
        chk({tag, " rise_pend"}, rise_pend, r);
        chk({tag, " fall_pend"}, fall_pend, f);
        chk({tag, " irq"},       {31'd0, irq},   {31'd0, i});
        chk({tag, " ready"},     {31'd0, ready}, {31'd0, rd});
    endtask

    initial begin
        // Edge numbers in comments count rising edges after reset release.
        tbl[0]  = '{32'h0,  32'h0,  32'h0, 1,  32'h0,  32'h0, 32'h0, 1'b0, 1'b0}; // e1
        tbl[1]  = '{32'h0,  32'h0,  32'h0, 10, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0}; // e11
        tbl[2]  = '{32'h0,  32'h0,  32'h0, 1,  32'h0,  32'h0, 32'h0, 1'b0, 1'b1}; // e12 ready
        tbl[3]  = '{32'h1,  32'h1,  32'h0, 11, 32'h0,  32'h0, 32'h0, 1'b0, 1'b1}; // e23
        tbl[4]  = '{32'h1,  32'h1,  32'h0, 1,  32'h1,  32'h1, 32'h0, 1'b0, 1'b1}; // e24 accept
        tbl[5]  = '{32'h1,  32'h1,  32'h0, 1,  32'h1,  32'h1, 32'h0, 1'b1, 1'b1}; // e25 irq
        tbl[6]  = '{32'h1,  32'h21, 32'h1, 2,  32'h1,  32'h0, 32'h0, 1'b0, 1'b1}; // e27 clear
        tbl[7]  = '{32'h1,  32'h21, 32'h0, 1,  32'h1,  32'h0, 32'h0, 1'b0, 1'b1}; // e28
        tbl[8]  = '{32'h21, 32'h21, 32'h0, 6,  32'h1,  32'h0, 32'h0, 1'b0, 1'b1}; // e34 glitch
        tbl[9]  = '{32'h1,  32'h21, 32'h0, 10, 32'h1,  32'h0, 32'h0, 1'b0, 1'b1}; // e44 rejected
        tbl[10] = '{32'h0,  32'h21, 32'h0, 11, 32'h1,  32'h0, 32'h0, 1'b0, 1'b1}; // e55
        tbl[11] = '{32'h0,  32'h21, 32'h1, 1,  32'h0,  32'h0, 32'h1, 1'b0, 1'b1}; // e56 set beats clr
        tbl[12] = '{32'h0,  32'h21, 32'h0, 1,  32'h0,  32'h0, 32'h1, 1'b1, 1'b1}; // e57
        tbl[13] = '{32'h0,  32'h21, 32'h1, 2,  32'h0,  32'h0, 32'h0, 1'b0, 1'b1}; // e59 clr alone

        XRESET_N = 1'b0;
        gpi_raw  = '0;
        irq_mask = '0;
        clr      = '0;
        step(3);
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        XRESET_N = 1'b1;

        foreach (tbl[i]) begin
            gpi_raw  = tbl[i].raw;
            irq_mask = tbl[i].mask;
            clr      = tbl[i].clr;
            step(1);
            clr = '0;
            if (tbl[i].cyc > 1) step(tbl[i].cyc - 1);
            chk_all($sformatf("v%0d", i), tbl[i].out, tbl[i].rise, tbl[i].fall,
                    tbl[i].irq, tbl[i].rdy);
        end

        // Bit 0 completes a rise while bit 7 is two ticks into its own debounce.
        gpi_raw = 32'h01;
        step(6);                                   // e65
        gpi_raw = 32'h81;
        step(8);                                   // e73
        chk_all("pre_rst", 32'h01, 32'h01, 32'h0, 1'b1, 1'b1);

        gpi_raw = 32'h89;
        #4 XRESET_N = 1'b0;
        #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(2);
        XRESET_N = 1'b1;

        // Levels held through reset settle after a full debounce, without flags.
        step(11);
        chk_all("post_rst e11", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1);
        chk_all("post_rst e12", 32'h89, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1);
        chk_all("post_rst e13", 32'h89, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
